multi_gate_unit: RTL and testbench

MULTI_GATE_UNIT -- requirements
Module: multi_gate_unit

---
 rtl/multi_gate_unit.sv | 125 ++++++++++++
 tb/tb_multi_gate_unit.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_gate_unit.sv
// Bitwise gate unit: pairwise op(input1, input2) or a BURST-beat fold of input1,
// behind a one-deep valid/ready output register. MULTI_GATE_UNIT_STATS_EN adds resultCount.
module multi_gate_unit #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned BURST = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] input1,
  input  logic [WIDTH-1:0] input2,
  input  logic [2:0]       opSel,
  input  logic             accMode,
  input  logic             inValid,
  output logic             inReady,
  output logic [WIDTH-1:0] result,
  output logic             outValid,
  input  logic             outReady,
  output logic             busy
`ifdef MULTI_GATE_UNIT_STATS_EN
  ,
  output logic [15:0]      resultCount
`endif
);

  typedef enum logic {IDLE, ACC} state_t;

  localparam logic [7:0] LAST = 8'(BURST - 1);

  state_t           state, state_n;
  logic [WIDTH-1:0] acc, acc_n;
  logic [7:0]       beat_cnt, beat_cnt_n;
  logic [2:0]       op_q, op_n;
  logic             mode_q, mode_n;

  logic             accept, consume, load;
  logic [2:0]       eff_op;
  logic             eff_mode;
  logic [WIDTH-1:0] left, right, gate_out;

  function automatic logic [WIDTH-1:0] gate(input logic [2:0] op,
                                            input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] b);
    case (op)
      3'b000:  gate = a & b;
      3'b001:  gate = a | b;
      3'b010:  gate = a ^ b;
      3'b011:  gate = ~(a & b);
      3'b100:  gate = ~(a | b);
      3'b101:  gate = ~(a ^ b);
      default: gate = a;
    endcase
  endfunction

  // Reset term keeps inReady high while reset is asserted.
  assign inReady = reset | ~outValid | outReady;
  assign accept  = inValid & inReady & ~reset;
  assign consume = outValid & outReady;
  assign busy    = (state == ACC);

  // Inside a burst the latched op/mode drive the datapath and acc is the left operand.
  assign eff_op   = (state == ACC) ? op_q   : opSel;
  assign eff_mode = (state == ACC) ? mode_q : accMode;
  assign left     = (state == ACC) ? acc    : input1;
  assign right    = (state == ACC) ? input1 : input2;
  assign gate_out = gate(eff_op, left, right);

  always_comb begin
    state_n    = state;
    acc_n      = acc;
    beat_cnt_n = beat_cnt;
    op_n       = op_q;
    mode_n     = mode_q;
    load       = 1'b0;
    if (accept) begin
      if (!eff_mode) begin
        load = 1'b1;
      end else if (state == IDLE) begin
        state_n    = ACC;
        op_n       = opSel;
        mode_n     = accMode;
        acc_n      = input1;
        beat_cnt_n = 8'd1;
      end else if (beat_cnt == LAST) begin
        load       = 1'b1;
        beat_cnt_n = '0;
        state_n    = IDLE;
      end else begin
        acc_n      = gate_out;
        beat_cnt_n = beat_cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      acc      <= '0;
      beat_cnt <= '0;
      op_q     <= '0;
      mode_q   <= 1'b0;
      result   <= '0;
      outValid <= 1'b0;
    end else begin
      state    <= state_n;
      acc      <= acc_n;
      beat_cnt <= beat_cnt_n;
      op_q     <= op_n;
      mode_q   <= mode_n;
      if (load) begin
        result   <= gate_out;
        outValid <= 1'b1;
      end else if (consume) begin
        outValid <= 1'b0;
      end
    end
  end

`ifdef MULTI_GATE_UNIT_STATS_EN
  always_ff @(posedge clk) begin
    if (reset)        resultCount <= '0;
    else if (consume) resultCount <= resultCount + 16'd1;
  end
`endif

endmodule

// File: tb/tb_multi_gate_unit.sv
// Self-checking bench for multi_gate_unit: directed scenarios plus random traffic
// checked against a beat-list reference model.
module tb_multi_gate_unit;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned BURST = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] input1, input2;
  logic [2:0]       opSel;
  logic             accMode, inValid, outReady;
  logic             inReady, outValid, busy;
  logic [WIDTH-1:0] result;
`ifdef MULTI_GATE_UNIT_STATS_EN
  logic [15:0]      resultCount;
`endif

  multi_gate_unit #(.WIDTH(WIDTH), .BURST(BURST)) dut (
    .clk(clk), .reset(reset), .input1(input1), .input2(input2), .opSel(opSel),
    .accMode(accMode), .inValid(inValid), .inReady(inReady), .result(result),
    .outValid(outValid), .outReady(outReady), .busy(busy)
`ifdef MULTI_GATE_UNIT_STATS_EN
    , .resultCount(resultCount)
`endif
  );

  always #5 clk = ~clk;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  // Reference model state
  logic             m_valid;
  logic [WIDTH-1:0] m_result;
  logic             m_busy;
  logic [2:0]       m_op;
  logic [WIDTH-1:0] m_beats[$];
  int unsigned      m_count;

  function automatic logic [WIDTH-1:0] ref_gate(input logic [2:0] op,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] r;
    if (op >= 3'd6) return a;
    case (op % 3)
      0:       r = a & b;
      1:       r = a | b;
      default: r = a ^ b;
    endcase
    return (op >= 3'd3) ? ~r : r;
  endfunction

  function automatic logic [WIDTH-1:0] ref_fold(input logic [2:0] op);
    logic [WIDTH-1:0] r;
    r = m_beats[0];
    for (int i = 1; i < m_beats.size(); i++) r = ref_gate(op, r, m_beats[i]);
    return r;
  endfunction

  // Advance the model by the inputs currently driven, then clock the DUT.
  task automatic tick();
    logic take, cons, ld;
    logic [WIDTH-1:0] val;
    take = inValid && (!m_valid || outReady) && !reset;
    cons = m_valid && outReady;
    ld = 1'b0;
    val = '0;
    if (reset) begin
      m_valid = 0; m_result = '0; m_busy = 0; m_op = '0; m_beats.delete(); m_count = 0;
    end else begin
      if (take) begin
        if (!m_busy && !accMode) begin
          ld = 1'b1; val = ref_gate(opSel, input1, input2);
        end else if (!m_busy) begin
          m_busy = 1'b1; m_op = opSel; m_beats.delete(); m_beats.push_back(input1);
        end else begin
          m_beats.push_back(input1);
          if (m_beats.size() == BURST) begin
            ld = 1'b1; val = ref_fold(m_op); m_busy = 1'b0; m_beats.delete();
          end
        end
      end
      if (cons) m_count = (m_count + 1) % 65536;
      if (ld) begin
        m_valid = 1'b1; m_result = val;
      end else if (cons) begin
        m_valid = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [2:0] op, input logic mode,
                      input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    opSel = op; accMode = mode; input1 = a; input2 = b; inValid = 1'b1;
    tick();
    inValid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; outReady = 1'b0; inValid = 1'b1; accMode = 1'b1; opSel = 3'd1;
    input1 = 8'hFF; input2 = 8'hFF;
    #1;
    vectors++;
    if (inReady !== 1'b1) begin
      miscompares++; $display("FAIL reset_inReady got %b want 1", inReady);
    end
    tick(); tick();
    inValid = 1'b0;
    vectors++;
    if ({result, outValid, busy} !== {8'h00, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_state got result=%h outValid=%b busy=%b want 00/0/0", result, outValid, busy);
    end
    reset = 1'b0;
    outReady = 1'b1;
    tick();
    vectors++;
    if ({outValid, busy} !== 2'b00) begin
      miscompares++; $display("FAIL reset_ignored_beat got outValid=%b busy=%b want 0/0", outValid, busy);
    end
  endtask

  task automatic test_pairwise();
    outReady = 1'b1;
    beat(3'b001, 1'b0, 8'h0F, 8'hF0);
    vectors++;
    if ({outValid, result} !== {1'b1, 8'hFF}) begin
      miscompares++; $display("FAIL pair_or got valid=%b result=%h want 1/ff", outValid, result);
    end
    beat(3'b101, 1'b0, 8'hAA, 8'hAA);
    vectors++;
    if ({outValid, result} !== {1'b1, 8'hFF}) begin
      miscompares++; $display("FAIL pair_xnor got valid=%b result=%h want 1/ff", outValid, result);
    end
    beat(3'b011, 1'b0, 8'hF0, 8'h3C);
    vectors++;
    if (result !== 8'hCF) begin
      miscompares++; $display("FAIL pair_nand got %h want cf", result);
    end
    tick();
    vectors++;
    if (outValid !== 1'b0) begin
      miscompares++; $display("FAIL pair_consume got outValid=%b want 0", outValid);
    end
  endtask

  task automatic test_accumulate();
    logic [WIDTH-1:0] b[4] = '{8'h01, 8'h02, 8'h04, 8'h08};
    outReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      beat(3'b010, 1'b1, b[i], 8'h00);
      vectors++;
      if (busy !== (i < 3)) begin
        miscompares++; $display("FAIL acc_busy beat%0d got %b want %b", i, busy, i < 3);
      end
    end
    vectors++;
    if ({outValid, result} !== {1'b1, 8'h0F}) begin
      miscompares++; $display("FAIL acc_xor got valid=%b result=%h want 1/0f", outValid, result);
    end
    tick();
  endtask

  task automatic test_latched_op();
    logic [WIDTH-1:0] b[4] = '{8'hFF, 8'hF0, 8'h3C, 8'h0F};
    outReady = 1'b1;
    beat(3'b000, 1'b1, b[0], 8'h00);
    for (int i = 1; i < 4; i++) beat(3'b001, 1'b0, b[i], 8'hFF);
    vectors++;
    if ({outValid, result} !== {1'b1, 8'h00}) begin
      miscompares++; $display("FAIL latched_op got valid=%b result=%h want 1/00", outValid, result);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    outReady = 1'b0;
    beat(3'b110, 1'b0, 8'h5A, 8'h00);
    for (int i = 0; i < 5; i++) begin
      inValid = 1'b1; opSel = 3'b000; input1 = 8'h11; input2 = 8'h22;
      #1;
      vectors++;
      if ({inReady, outValid, result} !== {1'b0, 1'b1, 8'h5A}) begin
        miscompares++;
        $display("FAIL stall%0d got inReady=%b valid=%b result=%h want 0/1/5a", i, inReady, outValid, result);
      end
      tick();
    end
    outReady = 1'b1; input1 = 8'h33; input2 = 8'h0F;
    #1;
    vectors++;
    if (inReady !== 1'b1) begin
      miscompares++; $display("FAIL release_inReady got %b want 1", inReady);
    end
    tick();
    inValid = 1'b0;
    vectors++;
    if ({outValid, result} !== {1'b1, 8'h03}) begin
      miscompares++; $display("FAIL no_bubble got valid=%b result=%h want 1/03", outValid, result);
    end
    tick();
  endtask

  task automatic test_reset_mid_burst();
    logic [WIDTH-1:0] b[4] = '{8'h01, 8'h02, 8'h04, 8'h08};
    outReady = 1'b1;
    beat(3'b001, 1'b1, 8'h80, 8'h00);
    beat(3'b001, 1'b1, 8'h40, 8'h00);
    reset = 1'b1; tick(); reset = 1'b0;
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++; $display("FAIL midreset_busy got %b want 0", busy);
    end
    for (int i = 0; i < 4; i++) beat(3'b001, 1'b1, b[i], 8'h00);
    vectors++;
    if ({outValid, result} !== {1'b1, 8'h0F}) begin
      miscompares++; $display("FAIL midreset_or got valid=%b result=%h want 1/0f", outValid, result);
    end
    tick();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      reset    = ($urandom_range(0, 59) == 0);
      inValid  = ($urandom_range(0, 3) != 0);
      outReady = ($urandom_range(0, 2) != 0);
      accMode  = ($urandom_range(0, 1) == 1);
      opSel    = 3'($urandom_range(0, 7));
      input1   = 8'($urandom);
      input2   = 8'($urandom);
      #1;
      vectors++;
      if (inReady !== (reset || !m_valid || outReady)) begin
        miscompares++; $display("FAIL rnd_inReady n=%0d got %b", n, inReady);
      end
      tick();
      vectors++;
      if ({outValid, busy, result} !== {m_valid, m_busy, m_result}) begin
        miscompares++;
        $display("FAIL rnd_out n=%0d got valid=%b busy=%b result=%h want %b/%b/%h",
                 n, outValid, busy, result, m_valid, m_busy, m_result);
      end
`ifdef MULTI_GATE_UNIT_STATS_EN
      vectors++;
      if (resultCount !== 16'(m_count)) begin
        miscompares++; $display("FAIL rnd_count n=%0d got %0d want %0d", n, resultCount, m_count);
      end
`endif
    end
    reset = 1'b0; inValid = 1'b0;
  endtask

  initial begin
    m_valid = 0; m_result = '0; m_busy = 0; m_op = '0; m_count = 0;
    reset = 1'b1; inValid = 1'b0; outReady = 1'b0; accMode = 1'b0;
    opSel = '0; input1 = '0; input2 = '0;
    @(posedge clk); #1;
    test_reset();
    test_pairwise();
    test_accumulate();
    test_latched_op();
    test_back_to_back();
    test_reset_mid_burst();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
